// File: rtl/adder_share_arb_pkg.sv
// Shared types and constants for the two-requester adder arbiter.
// The grant pick is a pure function of the request vector and the last grantee.
package adder_share_arb_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Single requester wins outright; on contention the one not served last wins.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/ripple_carry_gatelevel32.sv
// 32-bit ripple-carry adder built from an array of gate-level full adders.
// Purely combinational: the carry needs several cycles to settle through all bits.
module rca_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic axb;
  assign axb = a ^ b;
  assign s   = axb ^ ci;
  assign co  = (a & b) | (axb & ci);
endmodule

module ripple_carry_gatelevel32 (
  output logic [31:0] s,
  output logic        cout,
  input  logic [31:0] a,
  input  logic [31:0] b
);
  logic [32:0] c;

  assign c[0] = 1'b0;
  assign cout = c[32];

  rca_fa u_fa [31:0] (
    .a  (a),
    .b  (b),
    .ci (c[31:0]),
    .s  (s),
    .co (c[32:1])
  );
endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter and sequencer for a single shared ripple-carry adder.
// Latches the grantee's operands, waits SETTLE_CYCLES (1..15), registers the result, acks once.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [DATA_W-1:0]    a0_i,
  input  logic [DATA_W-1:0]    b0_i,
  input  logic [DATA_W-1:0]    a1_i,
  input  logic [DATA_W-1:0]    b1_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [DATA_W-1:0]    s_o,
  output logic                 cout_o,
  output logic                 gnt_id_o,
  output logic                 busy_o
);

  state_t            state;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;
  logic              carry;
  logic              gnt_nxt;

  assign gnt_nxt = rr_pick(req_i, last_grant);

  ripple_carry_gatelevel32 u_add (
    .s    (sum),
    .cout (carry),
    .a    (op_a),
    .b    (op_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      ack_o      <= '0;
      s_o        <= '0;
      cout_o     <= 1'b0;
      gnt_id_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i != '0) begin
            op_a       <= gnt_nxt ? a1_i : a0_i;
            op_b       <= gnt_nxt ? b1_i : b0_i;
            gnt_id_o   <= gnt_nxt;
            last_grant <= gnt_nxt;
            cnt        <= CNT_W'(SETTLE_CYCLES - 1);
            busy_o     <= 1'b1;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // Operands stay frozen here; the adder output is only trusted once cnt expires.
          if (cnt == '0) begin
            s_o    <= sum;
            cout_o <= carry;
            ack_o  <= NUM_REQ'(1) << gnt_id_o;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          ack_o  <= '0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on every ack.
module tb_adder_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, reqx;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  ack, ack1, ack15;
  logic [31:0] s, s1, s15;
  logic        cout, cout1, cout15, gnt, gnt1, gnt15, busy, busy1, busy15;

  always #5 clk = ~clk;

  adder_share_arb #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_i(req), .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .ack_o(ack), .s_o(s), .cout_o(cout), .gnt_id_o(gnt), .busy_o(busy));

  adder_share_arb #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_i(reqx), .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .ack_o(ack1), .s_o(s1), .cout_o(cout1), .gnt_id_o(gnt1), .busy_o(busy1));

  adder_share_arb #(.SETTLE_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .req_i(reqx), .a0_i(a0), .b0_i(b0), .a1_i(a1), .b1_i(b1),
    .ack_o(ack15), .s_o(s15), .cout_o(cout15), .gnt_id_o(gnt15), .busy_o(busy15));

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] s;
    logic        cout;
    logic        gnt;
  } exp_t;

  exp_t q[$];
  int   ack_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   acks_seen = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] a, input logic [31:0] sm, input logic c, input logic g);
    exp_t e;
    e.ack = a; e.s = sm; e.cout = c; e.gnt = g;
    q.push_back(e);
  endtask

  // Monitor: every ack pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack !== 2'b00) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=%0b expected=none", ack);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_ack", ack, e.ack);
        chk("sb_sum", s, e.s);
        chk("sb_cout", cout, e.cout);
        chk("sb_gnt", gnt, e.gnt);
      end
      ack_cyc.push_back(cyc);
      acks_seen++;
    end
  end

  // Single op on the SETTLE_CYCLES=2 instance, optionally disturbing a0 mid-settle.
  task automatic run_op(input logic [1:0] r, input logic chg, input logic [31:0] new_a0);
    int n = 0;
    int nb = 0;
    logic seen = 1'b0;
    req = r;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 1 && chg) a0 = new_a0;
      if (busy) nb++;
      if (ack != 2'b00) seen = 1'b1;
    end
    chk("ack_latency", n, 3);
    @(posedge clk); #1;
    if (busy) nb++;
    req = 2'b00;
    chk("busy_cycles", nb, 3);
  endtask

  task automatic wait_acks(input int target, input string nm);
    int n = 0;
    while (acks_seen < target && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (acks_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d expected=%0d", nm, acks_seen, target);
    end
  endtask

  initial begin
    int base, l1, l15, nb;
    logic [31:0] s15_cap;
    rst = 1'b1; req = 2'b00; reqx = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 2'b00);
    chk("rst_sum", s, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_gnt", gnt, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single request from requester 0
    a0 = 32'h00800800; b0 = 32'h00020000;
    push(2'b01, 32'h00820800, 1'b0, 1'b0);
    run_op(2'b01, 1'b0, 32'h0);
    repeat (2) @(posedge clk); #1;

    // Carry-out from requester 1
    a1 = 32'hFFFFFFFF; b1 = 32'h00000001;
    push(2'b10, 32'h00000000, 1'b1, 1'b1);
    run_op(2'b10, 1'b0, 32'h0);
    repeat (2) @(posedge clk); #1;

    // Contention: last grant was 1, so order is 0,1,0,1
    a0 = 32'h3; b0 = 32'h4; a1 = 32'h10000000; b1 = 32'h00200000;
    push(2'b01, 32'h00000007, 1'b0, 1'b0);
    push(2'b10, 32'h10200000, 1'b0, 1'b1);
    push(2'b01, 32'h00000007, 1'b0, 1'b0);
    push(2'b10, 32'h10200000, 1'b0, 1'b1);
    base = acks_seen;
    req = 2'b11;
    wait_acks(base + 4, "contention");
    #1 req = 2'b00;
    if (ack_cyc.size() >= 4) begin
      for (int i = ack_cyc.size() - 3; i < ack_cyc.size(); i++)
        chk("ack_interval", ack_cyc[i] - ack_cyc[i-1], 4);
    end
    repeat (3) @(posedge clk); #1;

    // Operand change during SETTLE must not affect the result
    a0 = 32'h00000001; b0 = 32'h00000001;
    push(2'b01, 32'h00000002, 1'b0, 1'b0);
    run_op(2'b01, 1'b1, 32'h7FFFFFFF);
    repeat (2) @(posedge clk); #1;

    // Reset during SETTLE: no ack, everything back to reset values
    a0 = 32'h5; b0 = 32'h6;
    req = 2'b01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ack", ack, 2'b00);
    chk("midrst_sum", s, 32'h0);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_gnt", gnt, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0; req = 2'b00;
    repeat (5) @(posedge clk); #1;
    a0 = 32'h3; b0 = 32'h4; a1 = 32'h10000000; b1 = 32'h00200000;
    push(2'b01, 32'h00000007, 1'b0, 1'b0);
    push(2'b10, 32'h10200000, 1'b0, 1'b1);
    base = acks_seen;
    req = 2'b11;
    wait_acks(base + 2, "post_reset");
    #1 req = 2'b00;
    repeat (3) @(posedge clk); #1;

    // Settle window extremes on the side instances
    a0 = 32'h00800800; b0 = 32'h00020000;
    l1 = 0; l15 = 0; nb = 0; s15_cap = '0;
    reqx = 2'b01;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk); #1;
      if (ack1 != 2'b00 && l1 == 0) l1 = n;
      if (ack15 != 2'b00 && l15 == 0) begin
        l15 = n;
        s15_cap = s15;
      end
      if (busy15) nb++;
      if (n == 16) reqx = 2'b00;
    end
    chk("settle1_latency", l1, 2);
    chk("settle15_latency", l15, 16);
    chk("settle15_busy", nb, 16);
    chk("settle15_sum", s15_cap, 32'h00820800);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_acks actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
